// File: rtl/memory_pkg.sv
// ============================================================================
// Module      : memory_pkg
// Description : Shared constants and the response record for
//               banked_word_memory and its read pipeline.
//               - NOP_WORD_DEFAULT   : word returned by an out-of-range fetch
//               - READ_LATENCY_MIN/MAX : legal read-latency window
//               - mem_resp_t         : {valid, err, data} at the default width
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package memory_pkg;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h2100_0000;
  localparam int          READ_LATENCY_MIN = 1;
  localparam int          READ_LATENCY_MAX = 3;

  // Response record at the default 32-bit word width. The read pipeline
  // declares the same layout locally so that it can follow DATA_WIDTH.
  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } mem_resp_t;

endpackage : memory_pkg

`default_nettype wire

// File: rtl/mem_read_pipe.sv
// ============================================================================
// Module      : mem_read_pipe
// Description : Fixed-latency delay line for read responses.
//               Each stage carries {valid, err, data}. A stage's data only
//               updates when a valid response passes through it, so the
//               final stage holds its data between response pulses.
// Ports       : clock, reset_n (async, active-low)
//               i_valid/i_err/i_data : response entering at the accept edge
//               o_valid/o_err/o_data : response after LATENCY cycles
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_read_pipe #(
  parameter int                    LATENCY    = 1,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_DATA = '0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  i_valid,
  input  logic                  i_err,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  output logic                  o_err,
  output logic [DATA_WIDTH-1:0] o_data
);

  typedef struct packed {
    logic                  valid;
    logic                  err;
    logic [DATA_WIDTH-1:0] data;
  } pipe_resp_t;

  pipe_resp_t w_in;
  assign w_in = '{valid: i_valid, err: i_err, data: i_data};

  for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
    pipe_resp_t w_prev;
    pipe_resp_t r_q;

    if (gi == 0) begin : g_first
      assign w_prev = w_in;
    end else begin : g_next
      assign w_prev = g_stage[gi-1].r_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_q <= '{valid: 1'b0, err: 1'b0, data: RESET_DATA};
      end else begin
        // err travels on its own so a write error can pulse without rvalid
        r_q.valid <= w_prev.valid;
        r_q.err   <= w_prev.err;
        if (w_prev.valid) begin
          r_q.data <= w_prev.data;
        end
      end
    end
  end

  assign o_valid = g_stage[LATENCY-1].r_q.valid;
  assign o_err   = g_stage[LATENCY-1].r_q.err;
  assign o_data  = g_stage[LATENCY-1].r_q.data;

endmodule : mem_read_pipe

`default_nettype wire

// File: rtl/banked_word_memory.sv
// ============================================================================
// Module      : banked_word_memory
// Description : Unified instruction/data word memory.
//               Port A : shared data port (d_*) and DMA loader (dma_*), DMA
//                        has strict priority; byte-strobed data writes.
//               Port B : read-only instruction fetch (i_*), always accepted.
//               Reads return after READ_LATENCY cycles. Out-of-range data
//               accesses pulse d_err (reads return 0); out-of-range fetches
//               return NOP_WORD; out-of-range DMA writes are dropped.
// Ports       : clock, reset_n (async, active-low)
//               d_req/d_we/d_strb/d_addr/d_wdata -> d_ready, d_rvalid,
//               d_rdata, d_err
//               dma_valid/dma_addr/dma_data -> dma_ready
//               i_req/i_addr -> i_rvalid, i_rdata
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module banked_word_memory
  import memory_pkg::*;
#(
  parameter int                    WORD_NUM     = 2048,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD     = DATA_WIDTH'(NOP_WORD_DEFAULT)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [DATA_WIDTH/8-1:0] d_strb,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  output logic                    d_ready,
  output logic                    d_rvalid,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_err,
  input  logic                    dma_valid,
  input  logic [ADDR_WIDTH-1:0]   dma_addr,
  input  logic [DATA_WIDTH-1:0]   dma_data,
  output logic                    dma_ready,
  input  logic                    i_req,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  output logic                    i_rvalid,
  output logic [DATA_WIDTH-1:0]   i_rdata
);

  localparam int c_IDX_W  = (WORD_NUM > 1) ? $clog2(WORD_NUM) : 1;
  localparam int c_STRB_W = DATA_WIDTH / 8;
  // One extra bit so the full address is compared against WORD_NUM and an
  // address past the array never wraps onto a low word.
  localparam logic [ADDR_WIDTH:0] c_WORD_LIMIT = (ADDR_WIDTH + 1)'(WORD_NUM);

  if (DATA_WIDTH % 8 != 0) begin : g_chk_width
    $error("banked_word_memory: DATA_WIDTH must be a multiple of 8");
  end
  if ((READ_LATENCY < READ_LATENCY_MIN) || (READ_LATENCY > READ_LATENCY_MAX)) begin : g_chk_latency
    $error("banked_word_memory: READ_LATENCY out of range");
  end

  logic [DATA_WIDTH-1:0] r_mem [WORD_NUM];

  logic                  w_d_in_range;
  logic                  w_dma_in_range;
  logic                  w_i_in_range;
  logic                  w_d_accept;
  logic                  w_wr_en;
  logic [c_IDX_W-1:0]    w_wr_idx;
  logic [DATA_WIDTH-1:0] w_wr_data;
  logic [c_STRB_W-1:0]   w_wr_strb;
  logic [DATA_WIDTH-1:0] w_d_rd_data;
  logic [DATA_WIDTH-1:0] w_i_rd_data;
  logic                  w_i_valid;
  logic                  w_i_err;

  // Port A arbitration: DMA always wins, nothing is accepted in reset.
  assign dma_ready  = reset_n;
  assign d_ready    = reset_n & ~dma_valid;
  assign w_d_accept = d_req & d_ready;

  assign w_d_in_range   = {1'b0, d_addr}   < c_WORD_LIMIT;
  assign w_dma_in_range = {1'b0, dma_addr} < c_WORD_LIMIT;
  assign w_i_in_range   = {1'b0, i_addr}   < c_WORD_LIMIT;

  // Single write port shared by DMA (full word) and data writes (strobed).
  // Gating with reset_n drops a beat presented while reset is asserted.
  assign w_wr_en   = dma_valid ? (reset_n & w_dma_in_range)
                               : (w_d_accept & d_we & w_d_in_range);
  assign w_wr_idx  = dma_valid ? dma_addr[c_IDX_W-1:0] : d_addr[c_IDX_W-1:0];
  assign w_wr_data = dma_valid ? dma_data : d_wdata;
  assign w_wr_strb = dma_valid ? {c_STRB_W{1'b1}} : d_strb;

  always_ff @(posedge clock) begin
    if (w_wr_en) begin
      for (int b = 0; b < c_STRB_W; b++) begin
        if (w_wr_strb[b]) begin
          r_mem[w_wr_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
        end
      end
    end
  end

  // Both read ports sample the array before the write lands (read-first).
  assign w_d_rd_data = w_d_in_range ? r_mem[d_addr[c_IDX_W-1:0]] : '0;
  assign w_i_rd_data = w_i_in_range ? r_mem[i_addr[c_IDX_W-1:0]] : NOP_WORD;

  mem_read_pipe #(
    .LATENCY    (READ_LATENCY),
    .DATA_WIDTH (DATA_WIDTH),
    .RESET_DATA ('0)
  ) u_d_pipe (
    .clock   (clock),
    .reset_n (reset_n),
    .i_valid (w_d_accept & ~d_we),
    .i_err   (w_d_accept & ~w_d_in_range),
    .i_data  (w_d_rd_data),
    .o_valid (d_rvalid),
    .o_err   (d_err),
    .o_data  (d_rdata)
  );

  mem_read_pipe #(
    .LATENCY    (READ_LATENCY),
    .DATA_WIDTH (DATA_WIDTH),
    .RESET_DATA (NOP_WORD)
  ) u_i_pipe (
    .clock   (clock),
    .reset_n (reset_n),
    .i_valid (i_req),
    .i_err   (1'b0),
    .i_data  (w_i_rd_data),
    .o_valid (w_i_valid),
    .o_err   (w_i_err),
    .o_data  (i_rdata)
  );

  // Fetch slots never carry an error; the gate keeps i_rvalid tied to a
  // clean slot should that ever change.
  assign i_rvalid = w_i_valid & ~w_i_err;

endmodule : banked_word_memory

`default_nettype wire

// File: tb/tb_banked_word_memory.sv
// ============================================================================
// Module      : tb_banked_word_memory
// Description : Self-checking bench for banked_word_memory (READ_LATENCY=3).
//               A word-array reference model predicts every response slot;
//               directed sequences cover strobes, arbitration, range limits,
//               pipelining, collisions and reset, followed by random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_banked_word_memory;

  localparam int          WN  = 2048;
  localparam int          DW  = 32;
  localparam int          AW  = 32;
  localparam int          L   = 3;
  localparam logic [31:0] NOP = 32'h2100_0000;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          d_req, d_we;
  logic [3:0]    d_strb;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ready, d_rvalid, d_err;
  logic [DW-1:0] d_rdata;
  logic          dma_valid;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_data;
  logic          dma_ready;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;

  always #5 clock = ~clock;

  banked_word_memory #(
    .WORD_NUM     (WN),
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .READ_LATENCY (L),
    .NOP_WORD     (NOP)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_strb    (d_strb),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ready   (d_ready),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .d_err     (d_err),
    .dma_valid (dma_valid),
    .dma_addr  (dma_addr),
    .dma_data  (dma_data),
    .dma_ready (dma_ready),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rvalid  (i_rvalid),
    .i_rdata   (i_rdata)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain word array plus expected-response slots indexed
  // by the cycle in which each response must be visible.
  logic [31:0] ref_mem [WN];
  int          cycle = 0;
  logic        ev_dv [8];
  logic        ev_de [8];
  logic [31:0] ev_dd [8];
  logic        ev_iv [8];
  logic [31:0] ev_id [8];

  task automatic clear_slots();
    for (int k = 0; k < 8; k++) begin
      ev_dv[k] = 1'b0; ev_de[k] = 1'b0; ev_dd[k] = '0;
      ev_iv[k] = 1'b0; ev_id[k] = '0;
    end
  endtask

  task automatic idle();
    d_req = 1'b0; d_we = 1'b0; d_strb = '0; d_addr = '0; d_wdata = '0;
    dma_valid = 1'b0; dma_addr = '0; dma_data = '0;
    i_req = 1'b0; i_addr = '0;
  endtask

  // One clock cycle with the inputs currently driven; predicts, steps, checks.
  task automatic tick();
    int          s;
    logic        acc;
    logic        d_oor;
    logic        i_oor;
    logic [31:0] mask;
    acc   = d_req && !dma_valid;
    d_oor = (d_addr >= 32'(WN));
    i_oor = (i_addr >= 32'(WN));
    s     = (cycle + L) % 8;
    if (acc && !d_we) begin
      ev_dv[s] = 1'b1;
      ev_de[s] = d_oor;
      if (d_oor) ev_dd[s] = '0;
      else       ev_dd[s] = ref_mem[d_addr];
    end else if (acc && d_we && d_oor) begin
      ev_de[s] = 1'b1;
    end
    if (i_req) begin
      ev_iv[s] = 1'b1;
      if (i_oor) ev_id[s] = NOP;
      else       ev_id[s] = ref_mem[i_addr];
    end
    // Writes after the reads: fetch in the same cycle sees the old word.
    if (dma_valid) begin
      if (dma_addr < 32'(WN)) ref_mem[dma_addr] = dma_data;
    end else if (acc && d_we && !d_oor) begin
      mask = '0;
      for (int b = 0; b < 4; b++) if (d_strb[b]) mask = mask | (32'hFF << (8 * b));
      ref_mem[d_addr] = (ref_mem[d_addr] & ~mask) | (d_wdata & mask);
    end
    @(posedge clock);
    cycle++;
    #1;
    s = cycle % 8;
    chk("d_rvalid", {31'b0, d_rvalid}, {31'b0, ev_dv[s]});
    chk("d_err", {31'b0, d_err}, {31'b0, ev_de[s]});
    if (ev_dv[s]) chk("d_rdata", d_rdata, ev_dd[s]);
    chk("i_rvalid", {31'b0, i_rvalid}, {31'b0, ev_iv[s]});
    if (ev_iv[s]) chk("i_rdata", i_rdata, ev_id[s]);
    ev_dv[s] = 1'b0; ev_de[s] = 1'b0; ev_iv[s] = 1'b0;
  endtask

  task automatic flush();
    idle();
    repeat (L + 1) tick();
  endtask

  task automatic d_write(input logic [31:0] a, input logic [31:0] v, input logic [3:0] st);
    idle(); d_req = 1'b1; d_we = 1'b1; d_addr = a; d_wdata = v; d_strb = st;
  endtask

  task automatic d_read(input logic [31:0] a);
    idle(); d_req = 1'b1; d_we = 1'b0; d_addr = a;
  endtask

  function automatic logic [31:0] rnd_addr();
    if ($urandom % 12 == 0) return 32'(WN) + ($urandom % 4);
    return $urandom % 64;
  endfunction

  logic        d_acc_prev;
  logic [31:0] old20;

  initial begin
    idle();
    clear_slots();
    // ---------------- reset values ----------------
    repeat (3) @(posedge clock);
    #1;
    chk("rst_d_rvalid", {31'b0, d_rvalid}, 32'd0);
    chk("rst_d_err", {31'b0, d_err}, 32'd0);
    chk("rst_i_rvalid", {31'b0, i_rvalid}, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_i_rdata", i_rdata, NOP);
    chk("rst_dma_ready", {31'b0, dma_ready}, 32'd0);
    reset_n = 1'b1;

    // Preload the working region through the DMA port.
    for (int a = 0; a < 64; a++) begin
      idle(); dma_valid = 1'b1; dma_addr = a; dma_data = $urandom;
      tick();
    end

    // ---------------- byte strobes ----------------
    d_write(5, 32'hDEAD_BEEF, 4'b1111); tick();
    d_write(5, 32'h0000_1200, 4'b0010); tick();
    d_read(5); tick();
    flush();
    chk("strb_word5", d_rdata, 32'hDEAD_12EF);

    // ---------------- arbitration ----------------
    for (int k = 0; k < 3; k++) begin
      d_write(50, 32'hA5A5_0050, 4'b1111);
      dma_valid = 1'b1; dma_addr = 40 + k; dma_data = 32'h0D0A_0000 + k;
      #0 chk("arb_d_ready_low", {31'b0, d_ready}, 32'd0);
      chk("arb_dma_ready", {31'b0, dma_ready}, 32'd1);
      tick();
    end
    d_write(50, 32'hA5A5_0050, 4'b1111);
    #0 chk("arb_d_ready_high", {31'b0, d_ready}, 32'd1);
    tick();
    for (int k = 0; k < 3; k++) begin d_read(40 + k); tick(); end
    d_read(50); tick();
    flush();
    chk("arb_word50", d_rdata, 32'hA5A5_0050);

    // ---------------- out of range ----------------
    d_read(WN); i_req = 1'b1; i_addr = WN + 1; tick();
    d_write(WN, 32'd7, 4'b1111); tick();
    d_read(0); tick();
    d_read(WN + 5); tick();
    d_read(32'hFFFF_FFFF); i_req = 1'b1; i_addr = 32'h8000_0005; tick();
    flush();
    chk("oor_fetch_hold", i_rdata, NOP);

    // ---------------- pipelining ----------------
    for (int a = 0; a < 8; a++) begin d_read(a); tick(); end
    flush();

    // ---------------- collision ----------------
    idle(); dma_valid = 1'b1; dma_addr = 9; dma_data = 32'd1; tick();
    d_write(9, 32'd2, 4'b1111); i_req = 1'b1; i_addr = 9; tick();
    d_read(9); i_req = 1'b1; i_addr = 9; tick();
    flush();
    chk("coll_new_fetch", i_rdata, 32'd2);
    chk("coll_new_read", d_rdata, 32'd2);

    // ---------------- random traffic ----------------
    d_acc_prev = 1'b1;
    idle();
    for (int n = 0; n < 400; n++) begin
      if (!d_req || d_acc_prev) begin
        d_req = ($urandom % 3 != 0); d_we = $urandom % 2;
        d_strb = $urandom; d_addr = rnd_addr(); d_wdata = $urandom;
      end
      dma_valid = ($urandom % 4 == 0); dma_addr = rnd_addr(); dma_data = $urandom;
      i_req = $urandom % 2; i_addr = rnd_addr();
      d_acc_prev = d_req && !dma_valid;
      tick();
    end
    flush();

    // ---------------- reset mid-flight, mid-DMA ----------------
    old20 = ref_mem[20];
    for (int k = 0; k < 2; k++) begin d_read(k); i_req = 1'b1; i_addr = k; tick(); end
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_d_rdata", d_rdata, 32'd0);
    chk("mid_rst_i_rdata", i_rdata, NOP);
    chk("mid_rst_d_ready", {31'b0, d_ready}, 32'd0);
    idle(); dma_valid = 1'b1; dma_addr = 20; dma_data = ~old20;
    for (int k = 0; k < 4; k++) begin
      @(posedge clock); cycle++; #1;
      chk("mid_rst_d_rvalid", {31'b0, d_rvalid}, 32'd0);
      chk("mid_rst_i_rvalid", {31'b0, i_rvalid}, 32'd0);
    end
    clear_slots();
    idle();
    reset_n = 1'b1;
    repeat (L + 1) tick();
    d_read(20); tick();
    flush();
    chk("rst_dma_dropped", d_rdata, old20);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_banked_word_memory

`default_nettype wire
